// File: rtl/program_memory_loader_pkg.sv
// program_loader_pkg: shared state encoding and constants for the program RAM loader.
package program_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/program_memory_loader_if.sv
// program_memory_loader_if: load command and byte-serial stream between loader and RAM owner.
interface program_memory_loader_if #(parameter int ADDR_WIDTH = 5);
    logic                  load_start;
    logic [ADDR_WIDTH:0]   load_length;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    modport master (output load_start, load_length, byte_valid, byte_data, input byte_ready);
    modport slave (input load_start, load_length, byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/loader_byte_assembler.sv
// loader_byte_assembler: packs accepted bytes MSB-first into a 32-bit word.
module loader_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);
    logic [1:0] byte_cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            word <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end

    assign word_ready = shift_en && byte_cnt == 2'd3;
endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: shares program RAM between CPU fetch and a byte-serial loader.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte before a load completes.
module program_memory_loader
    import program_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter int          ADDR_WIDTH   = 5,
    parameter logic [31:0] TEXT_BASE    = TEXT_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    program_memory_loader_if.slave lif,
    input  logic [31:0]           cpu_pc,
    output logic [31:0]           cpu_instr,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  pc_fault
);
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [31:0]         WINDOW = 32'(MEMORY_DEPTH * 4);

    state_t              state;
    logic [ADDR_WIDTH:0] word_ptr, length, ptr_next;
    logic [31:0]         pc_off, word;
    logic                byte_ready, shift_en, word_ready;

    assign lif.byte_ready = byte_ready;
    assign shift_en  = state == LOAD && lif.byte_valid;
    assign ptr_next  = word_ptr + 1'b1;
    assign pc_off    = cpu_pc - TEXT_BASE;
    assign pc_fault  = pc_off >= WINDOW || cpu_pc[1:0] != 2'b00;
    assign mem_addr  = state == IDLE ? pc_off[ADDR_WIDTH+1:2] : word_ptr[ADDR_WIDTH-1:0];
    assign cpu_instr = state == IDLE ? mem_rdata : NOP;
    assign mem_wdata = word;

    loader_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .shift_en  (shift_en),
        .byte_in   (lif.byte_data),
        .word      (word),
        .word_ready(word_ready)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset)
        if (!reset) csum <= '0;
        else if (state == IDLE) csum <= '0;
        else if (shift_en) csum <= csum + lif.byte_data;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            word_ptr <= '0;
            length <= '0;
            byte_ready <= 1'b0;
            cpu_stall <= 1'b0;
            mem_we <= 1'b0;
            loading <= 1'b0;
            load_done <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (lif.load_start) begin
                    if (lif.load_length > DEPTH) begin
                        load_error <= 1'b1;
                    end else begin
                        length <= lif.load_length;
                        word_ptr <= '0;
                        load_error <= 1'b0;
                        cpu_stall <= 1'b1;
                        loading <= 1'b1;
                        state <= lif.load_length == '0 ? DONE : LOAD;
                        byte_ready <= lif.load_length != '0;
                        load_done <= lif.load_length == '0;
                    end
                end
                LOAD: if (word_ready) begin
                    state <= WRITE;
                    byte_ready <= 1'b0;
                    mem_we <= 1'b1;
                end
                WRITE: begin
                    word_ptr <= ptr_next;
                    byte_ready <= 1'b1;
                    if (ptr_next == length) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state <= DONE;
                        byte_ready <= 1'b0;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state <= LOAD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (lif.byte_valid) begin
                    byte_ready <= 1'b0;
                    if (lif.byte_data == csum) begin
                        state <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        // Bad sum: abort without a done pulse; written words stay in RAM
                        state <= IDLE;
                        load_error <= 1'b1;
                        cpu_stall <= 1'b0;
                        loading <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    byte_ready <= 1'b0;
                    cpu_stall <= 1'b0;
                    loading <= 1'b0;
                end
            endcase
        end
endmodule
